multicycle_controller: RTL and testbench



---
 rtl/ctrl_pkg.sv | 50 +++++
 rtl/multicycle_controller_if.sv | 37 +++
 rtl/aludec.sv | 35 +++
 rtl/multicycle_controller.sv | 154 +++++++++++++++
 tb/tb_multicycle_controller.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I-subset control unit: FSM states,
// opcodes, ALU control codes and the internal aluop selector.
package ctrl_pkg;

   localparam int unsigned OP_W     = 7;
   localparam int unsigned F3_W     = 3;
   localparam int unsigned ALUC_W   = 3;
   localparam int unsigned ALUOP_W  = 2;
   localparam int unsigned SEL_W    = 2;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      JAL      = 4'd9,
      BRANCH   = 4'd10
   } statetype;

   localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
   localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
   localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;

   localparam logic [ALUC_W-1:0] ALU_ADD = 3'b000;
   localparam logic [ALUC_W-1:0] ALU_SUB = 3'b001;
   localparam logic [ALUC_W-1:0] ALU_AND = 3'b010;
   localparam logic [ALUC_W-1:0] ALU_OR  = 3'b011;
   localparam logic [ALUC_W-1:0] ALU_SLL = 3'b100;
   localparam logic [ALUC_W-1:0] ALU_SLT = 3'b101;
   localparam logic [ALUC_W-1:0] ALU_SRL = 3'b110;
   localparam logic [ALUC_W-1:0] ALU_XOR = 3'b111;

   localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
   localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
   localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [F3_W-1:0] F3_BEQ = 3'b000;
   localparam logic [F3_W-1:0] F3_BNE = 3'b001;
   localparam logic [F3_W-1:0] F3_BLT = 3'b100;
   localparam logic [F3_W-1:0] F3_BGE = 3'b101;

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction fields, ALU flags and datapath control lines between the
// controller (master) and the shared datapath (slave).
interface multicycle_controller_if;
   import ctrl_pkg::*;

   logic [OP_W-1:0]   op;
   logic [F3_W-1:0]   funct3;
   logic              funct7b5;
   logic              zero;
   logic              notZero;
   logic              LessThan;
   logic              GreaterEqual;

   logic              pcwrite;
   logic              adrsrc;
   logic              memwrite;
   logic              irwrite;
   logic [SEL_W-1:0]  resultsrc;
   logic [SEL_W-1:0]  alusrca;
   logic [SEL_W-1:0]  alusrcb;
   logic [SEL_W-1:0]  immsrc;
   logic              regwrite;
   logic [ALUC_W-1:0] alucontrol;

   modport master (
      input  op, funct3, funct7b5, zero, notZero, LessThan, GreaterEqual,
      output pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
             immsrc, regwrite, alucontrol
   );

   modport slave (
      output op, funct3, funct7b5, zero, notZero, LessThan, GreaterEqual,
      input  pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
             immsrc, regwrite, alucontrol
   );

endinterface

// File: rtl/aludec.sv
// ALU control decoder: maps aluop plus funct fields to the 3-bit ALU code.
// Shared with the single-cycle core, so it carries no state.
module aludec
   import ctrl_pkg::*;
(
   input  logic [ALUOP_W-1:0] aluop,
   input  logic [F3_W-1:0]    funct3,
   input  logic               op5,
   input  logic               funct7b5,
   output logic [ALUC_W-1:0]  alucontrol
);

   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         ALUOP_ADD: alucontrol = ALU_ADD;
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // Only register-register forms subtract; addi keeps add.
               3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b001:  alucontrol = ALU_SLL;
               3'b010:  alucontrol = ALU_SLT;
               3'b100:  alucontrol = ALU_XOR;
               3'b101:  alucontrol = ALU_SRL;
               3'b110:  alucontrol = ALU_OR;
               3'b111:  alucontrol = ALU_AND;
               default: alucontrol = ALU_ADD;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM: sequences fetch/decode/execute/writeback, resolves
// branches from the ALU flags and decodes the immediate format.
module multicycle_controller
   import ctrl_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   multicycle_controller_if.master bus
);

   statetype state;
   statetype state_d;

   logic               pcupdate;
   logic               branch;
   logic               taken;
   logic [ALUOP_W-1:0] aluop;
   logic               adrsrc_s;
   logic               memwrite_s;
   logic               irwrite_s;
   logic               regwrite_s;
   logic [SEL_W-1:0]   resultsrc_s;
   logic [SEL_W-1:0]   alusrca_s;
   logic [SEL_W-1:0]   alusrcb_s;

   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= state_d;
   end

   // Next state and Moore outputs of the current state.
   always_comb begin
      state_d     = FETCH;
      pcupdate    = 1'b0;
      branch      = 1'b0;
      aluop       = ALUOP_ADD;
      adrsrc_s    = 1'b0;
      memwrite_s  = 1'b0;
      irwrite_s   = 1'b0;
      regwrite_s  = 1'b0;
      resultsrc_s = 2'b00;
      alusrca_s   = 2'b00;
      alusrcb_s   = 2'b00;
      case (state)
         FETCH: begin
            irwrite_s   = 1'b1;
            alusrcb_s   = 2'b10;
            resultsrc_s = 2'b10;
            pcupdate    = 1'b1;
            state_d     = DECODE;
         end
         DECODE: begin
            alusrca_s = 2'b01;
            alusrcb_s = 2'b01;
            case (bus.op)
               OP_LOAD, OP_STORE: state_d = MEMADR;
               OP_RTYPE:          state_d = EXECUTER;
               OP_ITYPE:          state_d = EXECUTEI;
               OP_BRANCH:         state_d = BRANCH;
               OP_JAL:            state_d = JAL;
               default:           state_d = FETCH;
            endcase
         end
         MEMADR: begin
            alusrca_s = 2'b10;
            alusrcb_s = 2'b01;
            state_d   = (bus.op == OP_LOAD) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            adrsrc_s = 1'b1;
            state_d  = MEMWB;
         end
         MEMWB: begin
            resultsrc_s = 2'b01;
            regwrite_s  = 1'b1;
            state_d     = FETCH;
         end
         MEMWRITE: begin
            adrsrc_s   = 1'b1;
            memwrite_s = 1'b1;
            state_d    = FETCH;
         end
         EXECUTER: begin
            alusrca_s = 2'b10;
            aluop     = ALUOP_FUNCT;
            state_d   = ALUWB;
         end
         EXECUTEI: begin
            alusrca_s = 2'b10;
            alusrcb_s = 2'b01;
            aluop     = ALUOP_FUNCT;
            state_d   = ALUWB;
         end
         ALUWB: begin
            regwrite_s = 1'b1;
            state_d    = FETCH;
         end
         JAL: begin
            alusrca_s = 2'b01;
            alusrcb_s = 2'b10;
            pcupdate  = 1'b1;
            state_d   = ALUWB;
         end
         BRANCH: begin
            alusrca_s = 2'b10;
            aluop     = ALUOP_SUB;
            branch    = 1'b1;
            state_d   = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   // Unsupported funct3 values simply fall through as not taken.
   always_comb begin
      taken = 1'b0;
      case (bus.funct3)
         F3_BEQ:  taken = bus.zero;
         F3_BNE:  taken = bus.notZero;
         F3_BLT:  taken = bus.LessThan;
         F3_BGE:  taken = bus.GreaterEqual;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      bus.immsrc = 2'b00;
      case (bus.op)
         OP_STORE:  bus.immsrc = 2'b01;
         OP_BRANCH: bus.immsrc = 2'b10;
         OP_JAL:    bus.immsrc = 2'b11;
         default:   bus.immsrc = 2'b00;
      endcase
   end

   // Write enables are held off for as long as reset is asserted.
   assign bus.pcwrite   = ~reset & (pcupdate | (branch & taken));
   assign bus.memwrite  = ~reset & memwrite_s;
   assign bus.irwrite   = ~reset & irwrite_s;
   assign bus.regwrite  = ~reset & regwrite_s;
   assign bus.adrsrc    = adrsrc_s;
   assign bus.resultsrc = resultsrc_s;
   assign bus.alusrca   = alusrca_s;
   assign bus.alusrcb   = alusrcb_s;

   aludec u_aludec (
      .aluop      (aluop),
      .funct3     (bus.funct3),
      .op5        (bus.op[5]),
      .funct7b5   (bus.funct7b5),
      .alucontrol (bus.alucontrol)
   );

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed instruction sequences
// push per-cycle expected control words, a negedge monitor pops and compares.
module tb_multicycle_controller;
   import ctrl_pkg::*;

   typedef struct packed {
      logic       pcwrite;
      logic       adrsrc;
      logic       memwrite;
      logic       irwrite;
      logic [1:0] resultsrc;
      logic [1:0] alusrca;
      logic [1:0] alusrcb;
      logic [1:0] immsrc;
      logic       regwrite;
      logic [2:0] alucontrol;
   } exp_t;

   logic clk;
   logic reset;

   multicycle_controller_if bus ();

   multicycle_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   exp_t        sb_q[$];
   string       nm_q[$];
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   function automatic exp_t mk(input logic pcw, input logic adr, input logic mw,
                               input logic irw, input logic [1:0] rs,
                               input logic [1:0] sa, input logic [1:0] sb,
                               input logic [1:0] im, input logic rw,
                               input logic [2:0] ac);
      exp_t e;
      e.pcwrite    = pcw;
      e.adrsrc     = adr;
      e.memwrite   = mw;
      e.irwrite    = irw;
      e.resultsrc  = rs;
      e.alusrca    = sa;
      e.alusrcb    = sb;
      e.immsrc     = im;
      e.regwrite   = rw;
      e.alucontrol = ac;
      return e;
   endfunction

   // Hand-written control words for each state of the instruction flow.
   function automatic exp_t e_fetch(input logic [1:0] im);
      return mk(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, im, 1'b0, 3'b000);
   endfunction
   function automatic exp_t e_decode(input logic [1:0] im);
      return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, im, 1'b0, 3'b000);
   endfunction
   function automatic exp_t e_memadr(input logic [1:0] im);
      return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, im, 1'b0, 3'b000);
   endfunction
   function automatic exp_t e_memread(input logic [1:0] im);
      return mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, im, 1'b0, 3'b000);
   endfunction
   function automatic exp_t e_memwb(input logic [1:0] im);
      return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, im, 1'b1, 3'b000);
   endfunction
   function automatic exp_t e_memwrite(input logic [1:0] im, input logic mw);
      return mk(1'b0, 1'b1, mw, 1'b0, 2'b00, 2'b00, 2'b00, im, 1'b0, 3'b000);
   endfunction
   function automatic exp_t e_aluwb(input logic [1:0] im);
      return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, im, 1'b1, 3'b000);
   endfunction
   function automatic exp_t e_branch(input logic pcw);
      return mk(pcw, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 3'b001);
   endfunction

   task automatic setin(input logic [6:0] o, input logic [2:0] f3,
                        input logic f7, input logic [3:0] fl);
      bus.op           = o;
      bus.funct3       = f3;
      bus.funct7b5     = f7;
      bus.zero         = fl[3];
      bus.notZero      = fl[2];
      bus.LessThan     = fl[1];
      bus.GreaterEqual = fl[0];
   endtask

   // One clock: drive reset, queue the expected word for this cycle, advance.
   task automatic step(input logic r, input exp_t e, input string nm);
      reset = r;
      sb_q.push_back(e);
      nm_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   task automatic run_alu(input logic [6:0] o, input logic [2:0] f3,
                          input logic f7, input logic [2:0] ac, input string nm);
      setin(o, f3, f7, 4'b0000);
      step(1'b0, e_fetch(2'b00), {nm, "/fetch"});
      step(1'b0, e_decode(2'b00), {nm, "/decode"});
      if (o == OP_RTYPE)
         step(1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, ac),
              {nm, "/exec"});
      else
         step(1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, ac),
              {nm, "/exec"});
      step(1'b0, e_aluwb(2'b00), {nm, "/aluwb"});
   endtask

   task automatic run_br(input logic [2:0] f3, input logic [3:0] fl,
                         input logic pcw, input string nm);
      setin(OP_BRANCH, f3, 1'b0, fl);
      step(1'b0, e_fetch(2'b10), {nm, "/fetch"});
      step(1'b0, e_decode(2'b10), {nm, "/decode"});
      step(1'b0, e_branch(pcw), {nm, "/branch"});
   endtask

   always @(negedge clk) begin
      exp_t  e;
      exp_t  a;
      string n;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         n = nm_q.pop_front();
         a = {bus.pcwrite, bus.adrsrc, bus.memwrite, bus.irwrite, bus.resultsrc,
              bus.alusrca, bus.alusrcb, bus.immsrc, bus.regwrite, bus.alucontrol};
         n_checks++;
         if (a === e) n_pass++;
         else $display("FAIL %s: got %05h expected %05h", n, a, e);
      end
   end

   initial begin
      reset = 1'b1;
      setin(7'b0000000, 3'b000, 1'b0, 4'b0000);
      @(posedge clk);
      #1;

      // Reset held three cycles: FETCH decode visible, write enables off.
      for (int i = 0; i < 3; i++)
         step(1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 3'b000),
              "reset");

      // lw
      setin(OP_LOAD, 3'b010, 1'b0, 4'b0000);
      step(1'b0, e_fetch(2'b00), "lw/fetch");
      step(1'b0, e_decode(2'b00), "lw/decode");
      step(1'b0, e_memadr(2'b00), "lw/memadr");
      step(1'b0, e_memread(2'b00), "lw/memread");
      step(1'b0, e_memwb(2'b00), "lw/memwb");

      // sw
      setin(OP_STORE, 3'b010, 1'b0, 4'b0000);
      step(1'b0, e_fetch(2'b01), "sw/fetch");
      step(1'b0, e_decode(2'b01), "sw/decode");
      step(1'b0, e_memadr(2'b01), "sw/memadr");
      step(1'b0, e_memwrite(2'b01, 1'b1), "sw/memwrite");

      run_alu(OP_RTYPE, 3'b000, 1'b1, 3'b001, "sub");
      run_alu(OP_ITYPE, 3'b000, 1'b1, 3'b000, "addi");
      run_alu(OP_RTYPE, 3'b000, 1'b0, 3'b000, "add");
      run_alu(OP_RTYPE, 3'b101, 1'b1, 3'b110, "sra");
      run_alu(OP_RTYPE, 3'b100, 1'b0, 3'b111, "xor");
      run_alu(OP_ITYPE, 3'b110, 1'b0, 3'b011, "ori");
      run_alu(OP_RTYPE, 3'b111, 1'b0, 3'b010, "and");
      run_alu(OP_ITYPE, 3'b001, 1'b0, 3'b100, "slli");
      run_alu(OP_RTYPE, 3'b010, 1'b0, 3'b101, "slt");
      run_alu(OP_RTYPE, 3'b011, 1'b0, 3'b000, "f3_011");

      // Flags ordered {zero, notZero, LessThan, GreaterEqual}.
      run_br(3'b000, 4'b1001, 1'b1, "beq_t");
      run_br(3'b000, 4'b0110, 1'b0, "beq_nt");
      run_br(3'b001, 4'b1001, 1'b0, "bne_nt");
      run_br(3'b001, 4'b0110, 1'b1, "bne_t");
      run_br(3'b100, 4'b0110, 1'b1, "blt_t");
      run_br(3'b101, 4'b0110, 1'b0, "bge_nt");
      run_br(3'b101, 4'b1001, 1'b1, "bge_t");
      run_br(3'b010, 4'b1111, 1'b0, "f3_010");

      // jal
      setin(OP_JAL, 3'b000, 1'b0, 4'b0000);
      step(1'b0, e_fetch(2'b11), "jal/fetch");
      step(1'b0, e_decode(2'b11), "jal/decode");
      step(1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b11, 1'b0, 3'b000),
           "jal/jal");
      step(1'b0, e_aluwb(2'b11), "jal/aluwb");

      // Unknown op: two cycles, nothing written.
      setin(7'b0000000, 3'b000, 1'b0, 4'b1111);
      step(1'b0, e_fetch(2'b00), "nop/fetch");
      step(1'b0, e_decode(2'b00), "nop/decode");

      // sw abandoned by reset in MEMWRITE, then restart at FETCH.
      setin(OP_STORE, 3'b010, 1'b0, 4'b0000);
      step(1'b0, e_fetch(2'b01), "swrst/fetch");
      step(1'b0, e_decode(2'b01), "swrst/decode");
      step(1'b0, e_memadr(2'b01), "swrst/memadr");
      step(1'b1, e_memwrite(2'b01, 1'b0), "swrst/memwrite");
      step(1'b0, e_fetch(2'b01), "swrst/refetch");
      step(1'b0, e_decode(2'b01), "swrst/redecode");

      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
      if (sb_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain: %0d entries left, required 0", sb_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
